// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

    // sll $0,$0,0 encodes as all zeros.
    localparam logic [31:0] NOP      = 32'h0000_0000;
    localparam logic [4:0]  REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard detector: a load in EX whose destination
// is read by the instruction in ID.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       memread,
    input  logic [4:0] ex_rt,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       uses_rt,
    output logic       lu_hazard
);

    // $zero never carries a real dependency, even when a load targets it.
    assign lu_hazard = memread && (ex_rt != REG_ZERO) &&
                       ((ex_rt == rs) || (uses_rt && (ex_rt == rt)));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, MEM-stage redirects and
// data-memory freezes, with stall and redirect performance counters.
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LU_STALL_CYC = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rt,
    input  logic             exmem_branch_taken,
    input  logic             exmem_jump,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_we,
    output logic             idex_bubble,
    output logic             exmem_we,
    output logic             exmem_bubble,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] LU_RELOAD = 2'(LU_STALL_CYC - 1);

    hz_state_t  state, state_next;
    logic [1:0] lu_cnt, lu_cnt_next;
    logic       lu_hazard, redirect, mem_wait;

    hazard_detect u_detect (
        .memread   (idex_memread),
        .ex_rt     (idex_rt),
        .rs        (id_rs),
        .rt        (id_rt),
        .uses_rt   (id_uses_rt),
        .lu_hazard (lu_hazard)
    );

    assign redirect = exmem_branch_taken | exmem_jump;
    assign mem_wait = dmem_req & ~dmem_ready;
    assign busy     = (state != RUN);

    always_comb begin
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        ifid_flush   = 1'b0;
        idex_we      = 1'b1;
        idex_bubble  = 1'b0;
        exmem_we     = 1'b1;
        exmem_bubble = 1'b0;
        state_next   = state;
        lu_cnt_next  = lu_cnt;

        if (state == LU_STALL) begin
            if (mem_wait) begin
                // Freeze without consuming a bubble; the stall resumes after.
                {pc_we, ifid_we, idex_we, exmem_we} = 4'b0000;
            end else if (redirect) begin
                ifid_flush   = 1'b1;
                idex_bubble  = 1'b1;
                exmem_bubble = 1'b1;
                state_next   = RUN;
                lu_cnt_next  = 2'd0;
            end else begin
                pc_we       = 1'b0;
                ifid_we     = 1'b0;
                idex_bubble = 1'b1;
                if (lu_cnt <= 2'd1) begin
                    state_next  = RUN;
                    lu_cnt_next = 2'd0;
                end else begin
                    lu_cnt_next = lu_cnt - 2'd1;
                end
            end
        end else if ((state == RUN && mem_wait) || (state == MEM_WAIT && !dmem_ready)) begin
            {pc_we, ifid_we, idex_we, exmem_we} = 4'b0000;
            state_next = MEM_WAIT;
        end else begin
            // RUN, or the ready cycle of MEM_WAIT where a held redirect lands.
            state_next = RUN;
            if (redirect) begin
                ifid_flush   = 1'b1;
                idex_bubble  = 1'b1;
                exmem_bubble = 1'b1;
            end else if (lu_hazard) begin
                pc_we       = 1'b0;
                ifid_we     = 1'b0;
                idex_bubble = 1'b1;
                if (LU_STALL_CYC > 1) begin
                    state_next  = LU_STALL;
                    lu_cnt_next = LU_RELOAD;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            lu_cnt    <= 2'd0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state  <= state_next;
            lu_cnt <= lu_cnt_next;
            if (!pc_we)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (ifid_flush)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with one-bubble and three-bubble instances.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  id_rs, id_rt, idex_rt;
    logic        id_uses_rt, idex_memread, exmem_branch_taken, exmem_jump;
    logic        dmem_req, dmem_ready;

    logic        pc_we1, ifid_we1, ifid_flush1, idex_we1, idex_bubble1, exmem_we1, exmem_bubble1, busy1;
    logic        pc_we3, ifid_we3, ifid_flush3, idex_we3, idex_bubble3, exmem_we3, exmem_bubble3, busy3;
    logic [31:0] stall_cnt1, flush_cnt1, stall_cnt3, flush_cnt3;

    int vec = 0;
    int err = 0;

    // {pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, exmem_bubble, busy}
    localparam logic [7:0] O_RUN      = 8'b1101_0100;
    localparam logic [7:0] O_LU_RUN   = 8'b0001_1100;
    localparam logic [7:0] O_LU_STALL = 8'b0001_1101;
    localparam logic [7:0] O_RED_RUN  = 8'b1111_1110;
    localparam logic [7:0] O_RED_BUSY = 8'b1111_1111;
    localparam logic [7:0] O_FRZ_RUN  = 8'b0000_0000;
    localparam logic [7:0] O_FRZ_WAIT = 8'b0000_0001;
    localparam logic [7:0] O_READY    = 8'b1101_0101;

    wire [7:0] o1 = {pc_we1, ifid_we1, ifid_flush1, idex_we1, idex_bubble1, exmem_we1, exmem_bubble1, busy1};
    wire [7:0] o3 = {pc_we3, ifid_we3, ifid_flush3, idex_we3, idex_bubble3, exmem_we3, exmem_bubble3, busy3};

    always #5 clk = ~clk;

    hazard_ctrl #(.LU_STALL_CYC(1), .CNT_W(32)) dut1 (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .idex_memread(idex_memread), .idex_rt(idex_rt), .exmem_branch_taken(exmem_branch_taken),
        .exmem_jump(exmem_jump), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_we(pc_we1), .ifid_we(ifid_we1), .ifid_flush(ifid_flush1), .idex_we(idex_we1),
        .idex_bubble(idex_bubble1), .exmem_we(exmem_we1), .exmem_bubble(exmem_bubble1),
        .busy(busy1), .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
    );

    hazard_ctrl #(.LU_STALL_CYC(3), .CNT_W(32)) dut3 (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .idex_memread(idex_memread), .idex_rt(idex_rt), .exmem_branch_taken(exmem_branch_taken),
        .exmem_jump(exmem_jump), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_we(pc_we3), .ifid_we(ifid_we3), .ifid_flush(ifid_flush3), .idex_we(idex_we3),
        .idex_bubble(idex_bubble3), .exmem_we(exmem_we3), .exmem_bubble(exmem_bubble3),
        .busy(busy3), .stall_cnt(stall_cnt3), .flush_cnt(flush_cnt3)
    );

    task automatic drive_idle();
        id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 1'b0;
        idex_memread = 1'b0; idex_rt = 5'd0;
        exmem_branch_taken = 1'b0; exmem_jump = 1'b0;
        dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive_idle();
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        drive_idle();
        rst_n = 1'b0;
        #1;
        vec++;
        if (o1 !== O_RUN || o3 !== O_RUN) begin
            $display("FAIL reset_outputs got %b/%b exp %b", o1, o3, O_RUN); err++;
        end
        vec++;
        if (stall_cnt1 !== 32'd0 || flush_cnt1 !== 32'd0 || stall_cnt3 !== 32'd0 || flush_cnt3 !== 32'd0) begin
            $display("FAIL reset_counters got %0d %0d %0d %0d exp 0", stall_cnt1, flush_cnt1, stall_cnt3, flush_cnt3); err++;
        end
        #1 rst_n = 1'b1;
    endtask

    task automatic test_lu_single();
        do_reset();
        @(negedge clk);
        idex_memread = 1'b1; idex_rt = 5'd8; id_rs = 5'd8; id_rt = 5'd9;
        #1 vec++;
        if (o1 !== O_LU_RUN) begin
            $display("FAIL lu1_stall got %b exp %b", o1, O_LU_RUN); err++;
        end
        @(negedge clk);
        idex_memread = 1'b0; idex_rt = 5'd0;
        #1 vec++;
        if (o1 !== O_RUN) begin
            $display("FAIL lu1_release got %b exp %b", o1, O_RUN); err++;
        end
        vec++;
        if (stall_cnt1 !== 32'd1) begin
            $display("FAIL lu1_stall_cnt got %0d exp 1", stall_cnt1); err++;
        end
    endtask

    task automatic test_lu_triple();
        logic [7:0] exp_o [4];
        exp_o[0] = O_LU_RUN; exp_o[1] = O_LU_STALL; exp_o[2] = O_LU_STALL; exp_o[3] = O_RUN;
        do_reset();
        @(negedge clk);
        idex_memread = 1'b1; idex_rt = 5'd9; id_rs = 5'd3; id_rt = 5'd9; id_uses_rt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                @(negedge clk);
                idex_memread = 1'b0; idex_rt = 5'd0;
            end else if (i > 1) begin
                @(negedge clk);
            end
            #1 vec++;
            if (o3 !== exp_o[i]) begin
                $display("FAIL lu3_cycle%0d got %b exp %b", i, o3, exp_o[i]); err++;
            end
        end
        vec++;
        if (stall_cnt3 !== 32'd3) begin
            $display("FAIL lu3_stall_cnt got %0d exp 3", stall_cnt3); err++;
        end
    endtask

    task automatic test_lu_no_stall();
        do_reset();
        @(negedge clk);
        idex_memread = 1'b1; idex_rt = 5'd9; id_rs = 5'd3; id_rt = 5'd9; id_uses_rt = 1'b0;
        #1 vec++;
        if (o3 !== O_RUN) begin
            $display("FAIL lu_rt_unused got %b exp %b", o3, O_RUN); err++;
        end
        @(negedge clk);
        idex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
        #1 vec++;
        if (o3 !== O_RUN) begin
            $display("FAIL lu_reg_zero got %b exp %b", o3, O_RUN); err++;
        end
        @(negedge clk);
        vec++;
        if (stall_cnt3 !== 32'd0) begin
            $display("FAIL lu_none_stall_cnt got %0d exp 0", stall_cnt3); err++;
        end
    endtask

    task automatic test_redirect();
        do_reset();
        @(negedge clk);
        exmem_branch_taken = 1'b1;
        #1 vec++;
        if (o1 !== O_RED_RUN) begin
            $display("FAIL branch_flush got %b exp %b", o1, O_RED_RUN); err++;
        end
        @(negedge clk);
        drive_idle();
        #1 vec++;
        if (o1 !== O_RUN || flush_cnt1 !== 32'd1) begin
            $display("FAIL branch_after got %b cnt %0d exp %b cnt 1", o1, flush_cnt1, O_RUN); err++;
        end
        @(negedge clk);
        exmem_jump = 1'b1; idex_memread = 1'b1; idex_rt = 5'd8; id_rs = 5'd8;
        #1 vec++;
        if (o1 !== O_RED_RUN) begin
            $display("FAIL jump_with_lu got %b exp %b", o1, O_RED_RUN); err++;
        end
        @(negedge clk);
        drive_idle();
        #1 vec++;
        if (flush_cnt1 !== 32'd2 || stall_cnt1 !== 32'd0) begin
            $display("FAIL jump_counts got flush %0d stall %0d exp 2 0", flush_cnt1, stall_cnt1); err++;
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            logic [7:0] e;
            @(negedge clk);
            dmem_req   = (i < 5);
            dmem_ready = (i == 4);
            e = (i == 0) ? O_FRZ_RUN : (i < 4) ? O_FRZ_WAIT : (i == 4) ? O_READY : O_RUN;
            #1 vec++;
            if (o1 !== e) begin
                $display("FAIL mem_wait_cycle%0d got %b exp %b", i, o1, e); err++;
            end
        end
        vec++;
        if (stall_cnt1 !== 32'd4) begin
            $display("FAIL mem_wait_stall_cnt got %0d exp 4", stall_cnt1); err++;
        end
    endtask

    task automatic test_redirect_in_stall();
        do_reset();
        @(negedge clk);
        idex_memread = 1'b1; idex_rt = 5'd9; id_rs = 5'd9;
        #1 vec++;
        if (o3 !== O_LU_RUN) begin
            $display("FAIL red_stall_c1 got %b exp %b", o3, O_LU_RUN); err++;
        end
        @(negedge clk);
        idex_memread = 1'b0; idex_rt = 5'd0; exmem_branch_taken = 1'b1;
        #1 vec++;
        if (o3 !== O_RED_BUSY) begin
            $display("FAIL red_stall_c2 got %b exp %b", o3, O_RED_BUSY); err++;
        end
        @(negedge clk);
        drive_idle();
        #1 vec++;
        if (o3 !== O_RUN || stall_cnt3 !== 32'd1 || flush_cnt3 !== 32'd1) begin
            $display("FAIL red_stall_c3 got %b stall %0d flush %0d exp %b 1 1", o3, stall_cnt3, flush_cnt3, O_RUN); err++;
        end
    endtask

    task automatic test_redirect_mem_wait();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            logic [7:0] e;
            @(negedge clk);
            exmem_branch_taken = (i < 3);
            dmem_req   = (i < 3);
            dmem_ready = (i == 2);
            e = (i == 0) ? O_FRZ_RUN : (i == 1) ? O_FRZ_WAIT : (i == 2) ? O_RED_BUSY : O_RUN;
            #1 vec++;
            if (o1 !== e) begin
                $display("FAIL red_wait_cycle%0d got %b exp %b", i, o1, e); err++;
            end
        end
        vec++;
        if (flush_cnt1 !== 32'd1 || stall_cnt1 !== 32'd2) begin
            $display("FAIL red_wait_counts got flush %0d stall %0d exp 1 2", flush_cnt1, stall_cnt1); err++;
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        @(negedge clk);
        dmem_req = 1'b1; dmem_ready = 1'b0;
        @(negedge clk);
        #1 vec++;
        if (o1 !== O_FRZ_WAIT || stall_cnt1 !== 32'd1) begin
            $display("FAIL pre_reset got %b stall %0d exp %b 1", o1, stall_cnt1, O_FRZ_WAIT); err++;
        end
        rst_n = 1'b0;
        #1 vec++;
        if (busy1 !== 1'b0 || stall_cnt1 !== 32'd0 || o1 !== O_FRZ_RUN) begin
            $display("FAIL async_reset got busy %b stall %0d out %b exp 0 0 %b", busy1, stall_cnt1, o1, O_FRZ_RUN); err++;
        end
        #1 rst_n = 1'b1;
        drive_idle();
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_lu_single();
        test_lu_triple();
        test_lu_no_stall();
        test_redirect();
        test_mem_wait();
        test_redirect_in_stall();
        test_redirect_mem_wait();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
